// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Optional flush input `abort` is enabled by defining MULDIV_ABORT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] input_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               flush;

  logic               is_div_p0, neg_q_p0, neg_r_p0, b_zero_p0;
  logic [WIDTH-1:0]   opd_p0, a_raw_p0;
  logic [2*WIDTH-1:0] acc_p0;

  logic               is_signed, a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     msum, dtrial, ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

`ifdef MULDIV_ABORT_EN
  assign flush = abort && (state != IDLE);
`else
  assign flush = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Launch: signed ops run on magnitudes; sign flags fix up the result in FIX
  always_comb begin
    is_signed = ~op[0];
    a_sgn     = is_signed & operand_a[WIDTH-1];
    b_sgn     = is_signed & operand_b[WIDTH-1];
    a_abs     = abs_w(operand_a, is_signed);
    b_abs     = abs_w(operand_b, is_signed);
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    msum     = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, (acc_p0[0] ? opd_p0 : {WIDTH{1'b0}})};
    dtrial   = acc_p0[2*WIDTH-1:WIDTH-1];
    ddiff    = dtrial - {1'b0, opd_p0};
    dge      = (dtrial >= {1'b0, opd_p0});
    acc_step = is_div_p0 ? {(dge ? ddiff[WIDTH-1:0] : dtrial[WIDTH-1:0]), acc_p0[WIDTH-2:0], dge}
                         : {msum, acc_p0[WIDTH-1:1]};
  end

  always_comb begin
    prod   = neg_d(acc_p0, neg_q_p0);
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div_p0) begin
      if (b_zero_p0) begin
        res_lo = {WIDTH{1'b1}};
        res_hi = a_raw_p0;
      end else begin
        res_lo = neg_w(acc_p0[WIDTH-1:0], neg_q_p0);
        res_hi = neg_w(acc_p0[2*WIDTH-1:WIDTH], neg_r_p0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      is_div_p0 <= op[1];
      neg_q_p0  <= a_sgn ^ b_sgn;
      neg_r_p0  <= a_sgn;
      b_zero_p0 <= (operand_b == '0);
      a_raw_p0  <= operand_a;
      opd_p0    <= op[1] ? b_abs : a_abs;
      acc_p0    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
    end else if (state == RUN) begin
      acc_p0 <= acc_step;
    end
  end

  // Architectural HI/LO: MTHI/MTLO only when idle and not launching
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
          end else begin
            if (write_hi) hi <= input_data;
            if (write_lo) lo <= input_data;
          end
        end
        RUN: cnt <= cnt + CNT_W'(1);
        FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO are queued at launch and
// checked by an independent monitor on every done pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         write_hi = 1'b0;
  logic         write_lo = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [W-1:0] input_data = '0;
`ifdef MULDIV_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] exp_r;
  logic [W-1:0]   saved;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .write_hi(write_hi),
    .write_lo(write_lo),
    .input_data(input_data),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want done=0");
      end else begin
        exp_r = sb_q.pop_front();
        check("result_hi", hi, exp_r[2*W-1:W]);
        check("result_lo", lo, exp_r[W-1:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the launch edge
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input logic [2*W-1:0] e);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    if (push) sb_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom());
    operand_a = $urandom();
    operand_b = $urandom();
  endtask

  task automatic wait_done(input string name, input int exp_busy);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy === 1'b1) n++;
      @(negedge clock);
    end
    check({name, "_done_seen"}, W'(seen), W'(1));
    check({name, "_busy_cycles"}, W'(n), W'(exp_busy));
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] e);
    start_op(o, a, b, 1, e);
    wait_done(name, 33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    run_op("mult_neg",   2'b00, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("multu_b2b",  2'b01, 32'h00000002, 32'h00000003, 64'h00000000_00000006);
    run_op("mult_mixed", 2'b00, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000);
    run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_negb",   2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu",       2'b11, 32'd100,      32'd7,        64'h00000002_0000000E);
    run_op("divu_zero",  2'b11, 32'h00000005, 32'h00000000, 64'h00000005_FFFFFFFF);
    run_op("div_zero",   2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF);

    // MTHI, then MTHI+MTLO together
    write_hi = 1'b1;
    input_data = 32'h1234;
    @(negedge clock);
    write_hi = 1'b0;
    check("mthi", hi, 32'h1234);
    write_hi = 1'b1;
    write_lo = 1'b1;
    input_data = 32'h55;
    @(negedge clock);
    write_hi = 1'b0;
    write_lo = 1'b0;
    check("mthi_both", hi, 32'h55);
    check("mtlo_both", lo, 32'h55);

    // MTLO on the launch edge is dropped; MTLO and start while busy are ignored
    write_lo = 1'b1;
    input_data = 32'h77;
    start_op(2'b01, 32'd3, 32'd4, 1, 64'h00000000_0000000C);
    write_lo = 1'b0;
    check("mtlo_with_start", lo, 32'h55);
    repeat (3) @(negedge clock);
    write_lo = 1'b1;
    input_data = 32'hDEAD;
    start = 1'b1;
    op = 2'b00;
    operand_a = 32'd9;
    operand_b = 32'd9;
    @(negedge clock);
    write_lo = 1'b0;
    start = 1'b0;
    check("mtlo_busy", lo, 32'h55);
    wait_done("busy_ignore", 29);
    repeat (3) @(negedge clock);
    check("single_op_idle", W'(busy), W'(0));

    // Asynchronous reset mid-run discards the operation
    start_op(2'b01, 32'd7, 32'd9, 1, 64'd63);
    repeat (9) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("arst_no_restart", W'(busy), W'(0));

`ifdef MULDIV_ABORT_EN
    write_lo = 1'b1;
    input_data = 32'hAA;
    @(negedge clock);
    write_lo = 1'b0;
    saved = hi;
    start_op(2'b01, 32'd5, 32'd6, 0, 64'd0);
    repeat (4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_lo", lo, 32'hAA);
    check("abort_hi", hi, saved);
    repeat (40) @(negedge clock);
`endif

    check("queue_empty", W'(sb_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the register-file read operands A (rs) and B (rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers, including MTHI/MTLO writes; HI/LO feed the writeback mux (MFHI/MFLO).
- The control unit stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- operand_a  input  WIDTH  rs value (multiplicand / dividend), from register-file read port A.
- operand_b  input  WIDTH  rt value (multiplier / divisor), from register-file read port B.
- write_hi  input  1  MTHI strobe.
- write_lo  input  1  MTLO strobe.
- input_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the result lands in HI/LO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=lo=0; busy=0; done=0; counter=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States and transitions:
  - IDLE→RUN on start=1 at edge T. Operands and op are latched; abs values are taken for signed ops, with sign flags saved. Counter is cleared.
  - RUN: one radix-2 step per edge, for 32 edges (T+1..T+32).
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract.
  - RUN→FIX when the counter reaches WIDTH-1.
  - FIX: one edge (T+33). Applies sign correction, writes HI/LO, sets done=1, returns to IDLE.
- Timing:
  - busy=1 from after edge T through edge T+33 (33 cycles).
  - done=1 for exactly the cycle following edge T+33.
  - New HI/LO are visible in the same cycle done=1.
  - A new start is accepted in that same done cycle.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product, signed or unsigned per op.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide: quotient is truncated toward zero; remainder sign equals dividend sign.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=dividend (raw operand_a). Still takes the full 33 cycles.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000.
- start while busy: ignored.
- write_hi/write_lo:
  - In IDLE, the target register takes input_data at the next edge; both may be asserted together.
  - While busy: ignored (the hazard unit never issues them then).
  - Same edge as an accepted start: start wins and the write is dropped.
- Operands are latched at start; later changes on operand_a/b have no effect.
- op is only sampled at start.

Optional Feature:
- Macro: MULDIV_ABORT_EN
- Defined:
  - Adds input port abort (1 bit, placed after start).
  - abort=1 while busy: state→IDLE at the next edge; busy=0 after that edge.
  - No done pulse; hi/lo keep their pre-operation values.
  - abort in IDLE: no effect. abort and start together in IDLE: start is accepted.
  - Used on exception/branch flush.
- Not defined: no abort port; operations always run to completion unless reset.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003, start at edge T → busy=1 for 33 cycles; done pulse after edge T+33; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start in the done cycle with MULTU 2×3 → hi=0, lo=6, 33 cycles later.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=0x00000005 after 33 busy cycles. DIV a=0xFFFFFFF9, b=0 → hi=0xFFFFFFF9.
- write_hi=1 with input_data=0x1234 in IDLE → hi=0x1234 next cycle. write_lo during busy → lo unchanged. start pulsed during busy → no second op, single done.
- reset pulled low at RUN cycle 10 (asynchronously, mid-cycle) → busy=0, hi=lo=0 immediately; no done. With MULDIV_ABORT_EN: abort at RUN cycle 5 after MTLO 0xAA → IDLE next edge, lo=0xAA, no done.
